// File: rtl/nts_engine_tx_buffer.sv
// nts_engine_tx_buffer
// Per-engine single-packet transmit buffer. The engine writes one response packet
// as 64-bit words. The buffer then streams that packet to the extractor through
// the packet_available / fifo_rd_start / rd_valid / packet_read handshake.
module nts_engine_tx_buffer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LAST_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_areset,

    output logic                  o_wr_ready,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_last,
    input  logic [LAST_WIDTH-1:0] i_wr_bytes,
    input  logic                  i_wr_discard,
    output logic                  o_overflow,

    output logic                  o_packet_available,
    input  logic                  i_packet_read,
    output logic                  o_fifo_empty,
    input  logic                  i_fifo_rd_start,
    output logic                  o_fifo_rd_valid,
    output logic [DATA_WIDTH-1:0] o_fifo_rd_data,
    output logic [LAST_WIDTH-1:0] o_bytes_last_word
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    // One extra bit so that a packet filling the whole buffer can be counted.
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0]  WCNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_AVAILABLE,
        ST_STREAMING,
        ST_DRAINED
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   wcnt;
    logic [CNT_WIDTH-1:0]   rcnt;
    logic [DATA_WIDTH-1:0]  ram [DEPTH];

    logic                   accepting_c;
    logic                   discard_c;
    logic                   overflow_c;
    logic                   ram_we_c;
    logic [CNT_WIDTH-1:0]   wcnt_inc_c;
    logic [CNT_WIDTH-1:0]   rcnt_inc_c;

    // Write-side decode: discard beats a same-cycle word, a word arriving at full depth is dropped.
    always_comb begin
        accepting_c = (state == ST_EMPTY) || (state == ST_FILLING);
        discard_c   = (state == ST_FILLING) && i_wr_discard;
        overflow_c  = accepting_c && !discard_c && i_wr_valid && (wcnt == WCNT_FULL);
        ram_we_c    = accepting_c && !discard_c && i_wr_valid && (wcnt != WCNT_FULL);
        wcnt_inc_c  = wcnt + CNT_ONE;
        rcnt_inc_c  = rcnt + CNT_ONE;
    end

    // Packet storage; contents are only read back at addresses written for the resident packet.
    always_ff @(posedge i_clk) begin
        if (ram_we_c) begin
            ram[wcnt[ADDR_WIDTH-1:0]] <= i_wr_data;
        end
    end

    // Buffer state machine with registered handshake outputs and registered read port.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state              <= ST_EMPTY;
            wcnt               <= '0;
            rcnt               <= '0;
            o_wr_ready         <= 1'b1;
            o_overflow         <= 1'b0;
            o_packet_available <= 1'b0;
            o_fifo_empty       <= 1'b1;
            o_fifo_rd_valid    <= 1'b0;
            o_fifo_rd_data     <= '0;
            o_bytes_last_word  <= '0;
        end else begin
            o_overflow      <= 1'b0;
            o_fifo_rd_valid <= 1'b0;

            case (state)
                ST_EMPTY, ST_FILLING: begin
                    if (discard_c) begin
                        wcnt  <= '0;
                        state <= ST_EMPTY;
                    end else if (overflow_c) begin
                        o_overflow <= 1'b1;
                        wcnt       <= '0;
                        state      <= ST_EMPTY;
                    end else if (ram_we_c) begin
                        wcnt <= wcnt_inc_c;
                        if (i_wr_last) begin
                            state              <= ST_AVAILABLE;
                            o_bytes_last_word  <= i_wr_bytes;
                            o_packet_available <= 1'b1;
                            o_fifo_empty       <= 1'b0;
                            o_wr_ready         <= 1'b0;
                        end else begin
                            state <= ST_FILLING;
                        end
                    end
                end

                ST_AVAILABLE: begin
                    if (i_packet_read) begin
                        state              <= ST_EMPTY;
                        wcnt               <= '0;
                        o_packet_available <= 1'b0;
                        o_fifo_empty       <= 1'b1;
                        o_wr_ready         <= 1'b1;
                        o_bytes_last_word  <= '0;
                    end else if (i_fifo_rd_start) begin
                        // First word is read on the start edge so it is valid one cycle later.
                        o_fifo_rd_data  <= ram[ADDR_ZERO];
                        o_fifo_rd_valid <= 1'b1;
                        rcnt            <= CNT_ONE;
                        if (wcnt == CNT_ONE) begin
                            o_fifo_empty <= 1'b1;
                            state        <= ST_DRAINED;
                        end else begin
                            state <= ST_STREAMING;
                        end
                    end
                end

                ST_STREAMING: begin
                    if (i_packet_read) begin
                        state              <= ST_EMPTY;
                        wcnt               <= '0;
                        o_packet_available <= 1'b0;
                        o_fifo_empty       <= 1'b1;
                        o_wr_ready         <= 1'b1;
                        o_bytes_last_word  <= '0;
                    end else begin
                        o_fifo_rd_data  <= ram[rcnt[ADDR_WIDTH-1:0]];
                        o_fifo_rd_valid <= 1'b1;
                        rcnt            <= rcnt_inc_c;
                        if (rcnt_inc_c == wcnt) begin
                            o_fifo_empty <= 1'b1;
                            state        <= ST_DRAINED;
                        end
                    end
                end

                ST_DRAINED: begin
                    if (i_packet_read) begin
                        state              <= ST_EMPTY;
                        wcnt               <= '0;
                        o_packet_available <= 1'b0;
                        o_fifo_empty       <= 1'b1;
                        o_wr_ready         <= 1'b1;
                        o_bytes_last_word  <= '0;
                    end
                end

                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nts_engine_tx_buffer.sv
// Testbench for nts_engine_tx_buffer: randomized packets against a queue-based model,
// streamed words checked by a scoreboard monitor.
module tb_nts_engine_tx_buffer;

    localparam int unsigned DEPTH = 256;

    logic        i_clk = 1'b0;
    logic        i_areset;
    logic        o_wr_ready;
    logic        i_wr_valid;
    logic [63:0] i_wr_data;
    logic        i_wr_last;
    logic [3:0]  i_wr_bytes;
    logic        i_wr_discard;
    logic        o_overflow;
    logic        o_packet_available;
    logic        i_packet_read;
    logic        o_fifo_empty;
    logic        i_fifo_rd_start;
    logic        o_fifo_rd_valid;
    logic [63:0] o_fifo_rd_data;
    logic [3:0]  o_bytes_last_word;

    nts_engine_tx_buffer #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .LAST_WIDTH(4)) dut (
        .i_clk              (i_clk),
        .i_areset           (i_areset),
        .o_wr_ready         (o_wr_ready),
        .i_wr_valid         (i_wr_valid),
        .i_wr_data          (i_wr_data),
        .i_wr_last          (i_wr_last),
        .i_wr_bytes         (i_wr_bytes),
        .i_wr_discard       (i_wr_discard),
        .o_overflow         (o_overflow),
        .o_packet_available (o_packet_available),
        .i_packet_read      (i_packet_read),
        .o_fifo_empty       (o_fifo_empty),
        .i_fifo_rd_start    (i_fifo_rd_start),
        .o_fifo_rd_valid    (o_fifo_rd_valid),
        .o_fifo_rd_data     (o_fifo_rd_data),
        .o_bytes_last_word  (o_bytes_last_word)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] data;
        logic        empty;
        logic [3:0]  bytes;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] cur[$];
    logic [63:0] res[$];
    logic [3:0]  res_bytes;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid streamed word must match the head of the scoreboard.
    always @(negedge i_clk) begin
        if (i_areset === 1'b0 && o_fifo_rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rd_word", o_fifo_rd_data, 64'h0);
                check("unexpected_rd_valid", 64'(o_fifo_rd_valid), 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", o_fifo_rd_data, e.data);
                check("rd_empty_flag", 64'(o_fifo_empty), 64'(e.empty));
                check("rd_bytes_last", 64'(o_bytes_last_word), 64'(e.bytes));
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_wr_ready"}, 64'(o_wr_ready), 64'h1);
        check({tag, "_available"}, 64'(o_packet_available), 64'h0);
        check({tag, "_fifo_empty"}, 64'(o_fifo_empty), 64'h1);
        check({tag, "_rd_valid"}, 64'(o_fifo_rd_valid), 64'h0);
        check({tag, "_bytes"}, 64'(o_bytes_last_word), 64'h0);
    endtask

    // Writes n words; last asserted on the final word when use_last. Called at a negedge.
    task automatic write_pkt(input int n, input logic [3:0] bytes, input bit use_last);
        bit got_last;
        got_last = 0;
        for (int i = 0; i < n; i++) begin
            logic [63:0] d;
            bit          ovf;
            d = {$urandom(), $urandom()};
            check("wr_ready_fill", 64'(o_wr_ready), 64'h1);
            i_wr_valid = 1'b1;
            i_wr_data  = d;
            i_wr_last  = use_last && (i == n - 1);
            i_wr_bytes = bytes;
            ovf = (cur.size() == DEPTH);
            if (ovf) begin
                cur.delete();
            end else begin
                cur.push_back(d);
                if (i_wr_last) begin
                    res = cur;
                    res_bytes = bytes;
                    cur.delete();
                    got_last = 1;
                end
            end
            @(negedge i_clk);
            check("overflow_pulse", 64'(o_overflow), 64'(ovf));
        end
        i_wr_valid = 1'b0;
        i_wr_last  = 1'b0;
        if (got_last) begin
            check("avail_after_last", 64'(o_packet_available), 64'h1);
            check("ready_after_last", 64'(o_wr_ready), 64'h0);
            check("empty_after_last", 64'(o_fifo_empty), 64'h0);
            check("bytes_after_last", 64'(o_bytes_last_word), 64'(bytes));
        end else begin
            check("avail_no_last", 64'(o_packet_available), 64'h0);
            check("ready_no_last", 64'(o_wr_ready), 64'h1);
        end
    endtask

    // Streams the resident packet; abort_at>0 releases it while word abort_at is valid.
    task automatic stream(input int abort_at);
        int n;
        n = res.size();
        for (int i = 0; i < n; i++) begin
            exp_t e;
            if (abort_at > 0 && i >= abort_at) break;
            e.data  = res[i];
            e.empty = (i == n - 1);
            e.bytes = res_bytes;
            sb.push_back(e);
        end
        i_fifo_rd_start = 1'b1;
        @(negedge i_clk);
        i_fifo_rd_start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            check("rd_valid_run", 64'(o_fifo_rd_valid), 64'h1);
            if (k == abort_at) begin
                i_packet_read = 1'b1;
                @(negedge i_clk);
                i_packet_read = 1'b0;
                check_idle("abort");
                res.delete();
                return;
            end
            @(negedge i_clk);
        end
        check("rd_valid_end", 64'(o_fifo_rd_valid), 64'h0);
        check("avail_drained", 64'(o_packet_available), 64'h1);
        check("empty_drained", 64'(o_fifo_empty), 64'h1);
        check("bytes_drained", 64'(o_bytes_last_word), 64'(res_bytes));
        i_fifo_rd_start = 1'b1;
        @(negedge i_clk);
        i_fifo_rd_start = 1'b0;
        check("restart_ignored", 64'(o_fifo_rd_valid), 64'h0);
        i_packet_read = 1'b1;
        @(negedge i_clk);
        i_packet_read = 1'b0;
        check_idle("released");
        res.delete();
    endtask

    // Releases an available packet without streaming it (optionally with a same-cycle start).
    task automatic drop_pkt(input bit with_start);
        i_packet_read   = 1'b1;
        i_fifo_rd_start = with_start;
        @(negedge i_clk);
        i_packet_read   = 1'b0;
        i_fifo_rd_start = 1'b0;
        check_idle("drop");
        @(negedge i_clk);
        check("drop_no_valid", 64'(o_fifo_rd_valid), 64'h0);
        res.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        i_areset        = 1'b1;
        i_wr_valid      = 1'b0;
        i_wr_data       = '0;
        i_wr_last       = 1'b0;
        i_wr_bytes      = '0;
        i_wr_discard    = 1'b0;
        i_packet_read   = 1'b0;
        i_fifo_rd_start = 1'b0;
        repeat (2) @(negedge i_clk);
        check_idle("reset");
        check("reset_overflow", 64'(o_overflow), 64'h0);
        check("reset_rd_data", o_fifo_rd_data, 64'h0);
        i_areset = 1'b0;
        @(negedge i_clk);

        // Three-word packet, 5 bytes in last word.
        write_pkt(3, 4'd5, 1);
        stream(0);

        // Single-word packet.
        write_pkt(1, 4'd8, 1);
        stream(0);

        // Writes while a packet is resident are ignored.
        write_pkt(3, 4'd2, 1);
        i_wr_valid = 1'b1; i_wr_data = 64'hDEAD_BEEF_0000_0001; i_wr_last = 1'b1; i_wr_bytes = 4'd1;
        @(negedge i_clk);
        i_wr_valid = 1'b0; i_wr_last = 1'b0;
        check("ignored_ready", 64'(o_wr_ready), 64'h0);
        check("ignored_bytes", 64'(o_bytes_last_word), 64'h2);
        stream(0);

        // Full-depth packet is legal.
        write_pkt(DEPTH, 4'd7, 1);
        stream(0);

        // One word too many overflows and leaves the buffer empty.
        write_pkt(DEPTH + 1, 4'd3, 1);
        check_idle("overflow");

        // Discard after 4 words with a concurrent word, then a fresh 2-word packet.
        write_pkt(4, 4'd1, 0);
        i_wr_discard = 1'b1; i_wr_valid = 1'b1; i_wr_data = {$urandom(), $urandom()};
        cur.delete();
        @(negedge i_clk);
        i_wr_discard = 1'b0; i_wr_valid = 1'b0;
        check("discard_ready", 64'(o_wr_ready), 64'h1);
        check("discard_avail", 64'(o_packet_available), 64'h0);
        write_pkt(2, 4'd6, 1);
        stream(0);

        // Release during word 2 of 5.
        write_pkt(5, 4'd4, 1);
        stream(2);

        // Drop without streaming, and start+release in the same cycle.
        write_pkt(3, 4'd2, 1);
        drop_pkt(0);
        write_pkt(2, 4'd3, 1);
        drop_pkt(1);

        // Randomized packets.
        for (int r = 0; r < 10; r++) begin
            int n;
            int mode;
            n    = int'($urandom_range(1, 24));
            mode = int'($urandom_range(0, 3));
            write_pkt(n, 4'($urandom_range(1, 8)), 1);
            if (mode == 0)      stream(int'($urandom_range(1, n)));
            else if (mode == 1) drop_pkt(1'($urandom_range(0, 1)));
            else                stream(0);
        end

        // Asynchronous reset in the middle of streaming.
        write_pkt(6, 4'd5, 1);
        for (int i = 0; i < res.size(); i++) begin
            exp_t e;
            e.data = res[i]; e.empty = (i == res.size() - 1); e.bytes = res_bytes;
            sb.push_back(e);
        end
        i_fifo_rd_start = 1'b1;
        @(negedge i_clk);
        i_fifo_rd_start = 1'b0;
        @(negedge i_clk);
        #2 i_areset = 1'b1;
        #1;
        check_idle("midreset");
        check("midreset_rd_data", o_fifo_rd_data, 64'h0);
        check("midreset_overflow", 64'(o_overflow), 64'h0);
        sb.delete();
        res.delete();
        @(negedge i_clk);
        i_areset = 1'b0;
        @(negedge i_clk);
        write_pkt(2, 4'd8, 1);
        stream(0);

        repeat (2) @(negedge i_clk);
        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
